supersonic_if: RTL and testbench

SUPERSONIC_IF -- requirements
Module: supersonic_if

---
 rtl/supersonic_if.sv | 206 ++++++++++++++++++++
 tb/tb_supersonic_if.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/supersonic_if.sv
// Ultrasonic range sensor interface: issues the sensor trigger pulse, times
// the echo pulse and converts it to millimetres with a prescaler and a
// saturating mm counter. A cooldown guard spaces consecutive measurements.
module supersonic_if #(
    parameter int unsigned TRIG_CYCLES  = 500,
    parameter int unsigned CYC_PER_MM   = 291,
    parameter int unsigned COOLDOWN     = 3_000_000,
    parameter int unsigned RISE_TIMEOUT = 1_500_000,
    parameter int unsigned ECHO_MAX     = 1_250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    output logic        triggerSuc,
    output logic        valid,
    output logic [31:0] distance,
    output logic        sr_trig,
    input  logic        echo
);

    typedef enum logic [2:0] {
        IDLE,
        COOL,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE
    } state_t;

    localparam logic [31:0] MM_SAT = 32'hFFFF_FFFE;

    state_t      state;
    state_t      state_next;

    logic        echo_m;
    logic        echo_s;

    logic [31:0] cool_cnt;
    logic [31:0] trig_cnt;
    logic [31:0] rise_cnt;
    logic [31:0] n_cnt;
    logic [31:0] presc;
    logic [31:0] mm_cnt;
    logic [31:0] result;

    logic        cool_expired;
    logic        echo_tick;
    logic        n_at_max;

    logic        sr_trig_d;
    logic        trig_suc_d;
    logic        valid_d;

    assign cool_expired = (cool_cnt >= COOLDOWN);
    assign echo_tick    = echo_s && ((state == WAIT_ECHO) || (state == MEASURE));
    // True when the echo-high cycle being sampled now is the ECHO_MAX-th one.
    assign n_at_max     = ((n_cnt + 32'd1) >= ECHO_MAX);

    // Two-flop synchronizer for the asynchronous echo pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the distance result captured on entry to DONE.
    always_comb begin
        state_next = state;
        result     = mm_cnt;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = COOL;
                end
            end
            COOL: begin
                if (cool_expired) begin
                    state_next = TRIG;
                end
            end
            TRIG: begin
                if (trig_cnt >= TRIG_CYCLES - 1) begin
                    state_next = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                if (echo_s) begin
                    if (n_at_max) begin
                        state_next = DONE;
                        result     = '1;
                    end else begin
                        state_next = MEASURE;
                    end
                end else if (rise_cnt >= RISE_TIMEOUT - 1) begin
                    state_next = DONE;
                    result     = '1;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_next = DONE;
                    result     = mm_cnt;
                end else if (n_at_max) begin
                    state_next = DONE;
                    result     = '1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with the state they describe.
    always_comb begin
        sr_trig_d  = (state_next == TRIG);
        trig_suc_d = (state == TRIG) && (state_next == WAIT_ECHO);
        valid_d    = (state_next == DONE);
    end

    // Registered outputs; distance only changes alongside valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_trig    <= 1'b0;
            triggerSuc <= 1'b0;
            valid      <= 1'b0;
            distance   <= '0;
        end else begin
            sr_trig    <= sr_trig_d;
            triggerSuc <= trig_suc_d;
            valid      <= valid_d;
            if (valid_d) begin
                distance <= result;
            end
        end
    end

    // Trigger pulse width counter, runs only while in TRIG.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_cnt <= '0;
        end else if (state == TRIG) begin
            trig_cnt <= trig_cnt + 32'd1;
        end else begin
            trig_cnt <= '0;
        end
    end

    // Echo rise timeout counter, runs only while waiting for the echo.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_cnt <= '0;
        end else if (state == WAIT_ECHO) begin
            rise_cnt <= rise_cnt + 32'd1;
        end else begin
            rise_cnt <= '0;
        end
    end

    // Echo-high measurement: raw cycle count plus prescaler/mm pair, cleared while the trigger pulse is out.
    always_ff @(posedge clk) begin
        if (rst || (state == TRIG)) begin
            n_cnt  <= '0;
            presc  <= '0;
            mm_cnt <= '0;
        end else if (echo_tick) begin
            n_cnt <= n_cnt + 32'd1;
            if (presc >= CYC_PER_MM - 1) begin
                presc <= '0;
                if (mm_cnt != MM_SAT) begin
                    mm_cnt <= mm_cnt + 32'd1;
                end
            end else begin
                presc <= presc + 32'd1;
            end
        end
    end

    // Cooldown counter: restarts in DONE, saturates at COOLDOWN, reads expired after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cool_cnt <= 32'(COOLDOWN);
        end else if (state == DONE) begin
            cool_cnt <= '0;
        end else if (!cool_expired) begin
            cool_cnt <= cool_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_supersonic_if.sv
// Directed bench for supersonic_if with small parameters so every scenario
// completes in a few hundred cycles.
module tb_supersonic_if;

    logic        clk;
    logic        rst;
    logic        trigger;
    logic        triggerSuc;
    logic        valid;
    logic [31:0] distance;
    logic        sr_trig;
    logic        echo;

    int passed = 0;
    int total  = 0;

    // Event monitor state, updated at every negedge.
    int          cyc           = 0;
    logic        sr_prev       = 1'b0;
    int          trig_hi_total = 0;
    int          run           = 0;
    int          last_run      = 0;
    int          rise_total    = 0;
    int          last_rise_cyc = 0;
    int          suc_total     = 0;
    int          last_suc_cyc  = 0;
    int          valid_total   = 0;
    int          last_valid_cyc = 0;
    int          orphan        = 0;

    supersonic_if #(
        .TRIG_CYCLES (4),
        .CYC_PER_MM  (3),
        .COOLDOWN    (20),
        .RISE_TIMEOUT(50),
        .ECHO_MAX    (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .triggerSuc(triggerSuc),
        .valid     (valid),
        .distance  (distance),
        .sr_trig   (sr_trig),
        .echo      (echo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record pulses and their cycle numbers mid-cycle.
    always @(negedge clk) begin
        cyc     <= cyc + 1;
        sr_prev <= sr_trig;
        if (sr_trig === 1'b1) begin
            trig_hi_total <= trig_hi_total + 1;
            run           <= run + 1;
        end else begin
            run <= 0;
        end
        if ((sr_trig === 1'b1) && (sr_prev !== 1'b1)) begin
            rise_total    <= rise_total + 1;
            last_rise_cyc <= cyc;
        end
        if ((sr_trig !== 1'b1) && (sr_prev === 1'b1)) begin
            last_run <= run;
        end
        if (triggerSuc === 1'b1) begin
            suc_total    <= suc_total + 1;
            last_suc_cyc <= cyc;
        end
        if (valid === 1'b1) begin
            valid_total    <= valid_total + 1;
            last_valid_cyc <= cyc;
            if (valid_total >= suc_total) begin
                orphan <= orphan + 1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        trigger = 1'b0;
        echo    = 1'b0;
        repeat (3) step();
        total++; if (sr_trig !== 1'b0) $display("FAIL reset_sr_trig: got %b expected 0", sr_trig); else passed++;
        total++; if (triggerSuc !== 1'b0) $display("FAIL reset_triggerSuc: got %b expected 0", triggerSuc); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else passed++;
        total++; if (distance !== 32'd0) $display("FAIL reset_distance: got %h expected 0", distance); else passed++;
        rst = 1'b0;
        step();
    endtask

    // One full request with an echo of echo_len cycles.
    task automatic test_measure(input int echo_len, input logic [31:0] exp_dist);
        int s0, v0, h0, n;
        s0 = suc_total; v0 = valid_total; h0 = trig_hi_total;
        trigger = 1'b1;
        n = 0;
        while (suc_total == s0 && n < 300) begin step(); n++; end
        trigger = 1'b0;
        total++; if (suc_total == s0) $display("FAIL meas_suc_timeout len=%0d: got no triggerSuc expected one", echo_len); else passed++;
        echo = 1'b1;
        repeat (echo_len) step();
        echo = 1'b0;
        n = 0;
        while (valid_total == v0 && n < 300) begin step(); n++; end
        total++; if (valid_total == v0) $display("FAIL meas_valid_timeout len=%0d: got no valid expected one", echo_len); else passed++;
        total++; if (distance !== exp_dist) $display("FAIL meas_distance len=%0d: got %h expected %h", echo_len, distance, exp_dist); else passed++;
        total++; if (last_valid_cyc - last_suc_cyc != echo_len + 3) $display("FAIL meas_latency len=%0d: got %0d expected %0d", echo_len, last_valid_cyc - last_suc_cyc, echo_len + 3); else passed++;
        repeat (5) step();
        total++; if (distance !== exp_dist) $display("FAIL meas_hold len=%0d: got %h expected %h", echo_len, distance, exp_dist); else passed++;
        total++; if (suc_total - s0 != 1) $display("FAIL meas_suc_count len=%0d: got %0d expected 1", echo_len, suc_total - s0); else passed++;
        total++; if (valid_total - v0 != 1) $display("FAIL meas_valid_count len=%0d: got %0d expected 1", echo_len, valid_total - v0); else passed++;
        total++; if (trig_hi_total - h0 != 4) $display("FAIL meas_trig_cycles len=%0d: got %0d expected 4", echo_len, trig_hi_total - h0); else passed++;
        total++; if (last_run != 4) $display("FAIL meas_trig_run len=%0d: got %0d expected 4", echo_len, last_run); else passed++;
    endtask

    task automatic test_timeout();
        int s0, v0, n;
        s0 = suc_total; v0 = valid_total;
        trigger = 1'b1;
        n = 0;
        while (suc_total == s0 && n < 300) begin step(); n++; end
        trigger = 1'b0;
        n = 0;
        while (valid_total == v0 && n < 300) begin step(); n++; end
        total++; if (valid_total == v0) $display("FAIL timeout_valid: got no valid expected one"); else passed++;
        total++; if (distance !== 32'hFFFF_FFFF) $display("FAIL timeout_distance: got %h expected ffffffff", distance); else passed++;
        total++; if (last_valid_cyc - last_suc_cyc != 50) $display("FAIL timeout_latency: got %0d expected 50", last_valid_cyc - last_suc_cyc); else passed++;
        repeat (5) step();
        total++; if (valid_total - v0 != 1) $display("FAIL timeout_valid_count: got %0d expected 1", valid_total - v0); else passed++;
    endtask

    task automatic test_out_of_range();
        int s0, v0, n;
        s0 = suc_total; v0 = valid_total;
        trigger = 1'b1;
        n = 0;
        while (suc_total == s0 && n < 300) begin step(); n++; end
        trigger = 1'b0;
        echo = 1'b1;
        repeat (150) step();
        echo = 1'b0;
        repeat (10) step();
        total++; if (valid_total - v0 != 1) $display("FAIL oor_valid_count: got %0d expected 1", valid_total - v0); else passed++;
        total++; if (distance !== 32'hFFFF_FFFF) $display("FAIL oor_distance: got %h expected ffffffff", distance); else passed++;
        total++; if (last_valid_cyc - last_suc_cyc != 102) $display("FAIL oor_latency: got %0d expected 102", last_valid_cyc - last_suc_cyc); else passed++;
    endtask

    task automatic test_echo_idle();
        int v0, r0;
        v0 = valid_total; r0 = rise_total;
        echo = 1'b1;
        repeat (10) step();
        echo = 1'b0;
        repeat (5) step();
        total++; if (valid_total != v0) $display("FAIL idle_echo_valid: got %0d expected 0", valid_total - v0); else passed++;
        total++; if (rise_total != r0) $display("FAIL idle_echo_trig: got %0d expected 0", rise_total - r0); else passed++;
    endtask

    task automatic test_back_to_back();
        int s0, v0, n, sp, vp, prev_valid;
        s0 = suc_total; v0 = valid_total;
        prev_valid = 0;
        trigger = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sp = suc_total; vp = valid_total;
            n = 0;
            while (suc_total == sp && n < 300) begin step(); n++; end
            total++; if (suc_total == sp) $display("FAIL b2b_suc_timeout k=%0d: got no triggerSuc expected one", k); else passed++;
            if (k > 0) begin
                total++; if (last_rise_cyc - prev_valid < 20) $display("FAIL b2b_cooldown k=%0d: got gap %0d expected >= 20", k, last_rise_cyc - prev_valid); else passed++;
            end
            echo = 1'b1;
            repeat (6) step();
            echo = 1'b0;
            n = 0;
            while (valid_total == vp && n < 300) begin step(); n++; end
            total++; if (distance !== 32'd2) $display("FAIL b2b_distance k=%0d: got %h expected 2", k, distance); else passed++;
            prev_valid = last_valid_cyc;
        end
        trigger = 1'b0;
        repeat (40) step();
        total++; if (suc_total - s0 != 5) $display("FAIL b2b_suc_count: got %0d expected 5", suc_total - s0); else passed++;
        total++; if (valid_total - v0 != 5) $display("FAIL b2b_valid_count: got %0d expected 5", valid_total - v0); else passed++;
    endtask

    task automatic test_reset_mid();
        int s0, v0, n;
        s0 = suc_total;
        trigger = 1'b1;
        n = 0;
        while (suc_total == s0 && n < 300) begin step(); n++; end
        trigger = 1'b0;
        echo = 1'b1;
        repeat (10) step();
        v0 = valid_total;
        rst = 1'b1;
        step();
        total++; if (sr_trig !== 1'b0) $display("FAIL rstmid_sr_trig: got %b expected 0", sr_trig); else passed++;
        total++; if (triggerSuc !== 1'b0) $display("FAIL rstmid_triggerSuc: got %b expected 0", triggerSuc); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", valid); else passed++;
        total++; if (distance !== 32'd0) $display("FAIL rstmid_distance: got %h expected 0", distance); else passed++;
        rst = 1'b0;
        repeat (10) step();
        echo = 1'b0;
        repeat (80) step();
        total++; if (valid_total != v0) $display("FAIL rstmid_no_valid: got %0d expected 0", valid_total - v0); else passed++;
    endtask

    initial begin
        test_reset();
        test_measure(30, 32'd10);
        test_measure(2, 32'd0);
        test_measure(3, 32'd1);
        test_timeout();
        test_out_of_range();
        test_echo_idle();
        test_back_to_back();
        test_reset_mid();
        test_measure(9, 32'd3);
        total++; if (orphan != 0) $display("FAIL orphan_valid: got %0d expected 0", orphan); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
